// File: rtl/pe_stack_bus_upstream_tx_pkg.sv
// Shared definitions for the PE-side upstream stack-bus transmitter.
// Latency: n/a (types, constants and a header-packing helper only).
// Backpressure: n/a.
package pe_stack_bus_upstream_tx_pkg;

  // Default bus payload width; the header occupies the low 32 bits.
  localparam int STUP_DATA_WIDTH = 32;

  // Beat framing encodings, shared by the core side and the bus side.
  typedef enum logic [1:0] {
    CNTL_SOM = 2'd0,  // single-beat packet
    CNTL_SOP = 2'd1,
    CNTL_MOP = 2'd2,
    CNTL_EOP = 2'd3
  } cntl_e;

  // Header beat field positions.
  localparam int HDR_PE_ID_LSB = 24;
  localparam int HDR_LEN_LSB   = 16;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } tx_state_e;

  // Builds the 32-bit header word: PE_ID in [31:24], payload beat count in [23:16].
  function automatic logic [31:0] make_hdr(input logic [7:0] pe_id, input logic [7:0] len);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_PE_ID_LSB +: 8] = pe_id;
    hdr[HDR_LEN_LSB +: 8]   = len;
    return hdr;
  endfunction

endpackage

// File: rtl/pe_stack_bus_upstream_fifo.sv
// Generic synchronous FIFO with full/empty/occupancy count; DEPTH must be a power of 2.
// Latency: a pushed word is visible at pop_dat_o the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full is registered, no pop-through.
// Ports: clk_i, reset_i (sync, active-high), push_i/push_dat_i, pop_i/pop_dat_o, full_o, empty_o, count_o.
module pe_stack_bus_upstream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop leaves the occupancy unchanged.
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/pe_stack_bus_upstream_tx.sv
// PE-side upstream stack-bus transmitter: frames core beats into packets, prepends a PE_ID/length header.
// Latency: core EOP/SOM accepted at edge N -> header valid the cycle after edge N when the FSM is idle.
// Backpressure: core ready = !data_fifo_full && !len_queue_full (registered); bus outputs hold until ready.
// Ports: clk, reset_poweron (sync, active-high); core side pe__stUp__{valid,cntl,data} / stUp__pe__ready;
//        bus side pe__sys__stUp__{valid,cntl,data} / sys__pe__stUp__ready;
//        status stUp__pe__framing_error (sticky), stUp__pe__pkts_sent (wrapping packet count).
// Constraints: DATA_WIDTH >= 32, FIFO_DEPTH power of 2, MAX_PKT_BEATS <= FIFO_DEPTH and <= 255.
module pe_stack_bus_upstream_tx
  import pe_stack_bus_upstream_tx_pkg::*;
#(
  parameter int PE_ID         = 0,
  parameter int DATA_WIDTH    = STUP_DATA_WIDTH,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_PKT_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  pe__stUp__valid,
  input  logic [1:0]            pe__stUp__cntl,
  input  logic [DATA_WIDTH-1:0] pe__stUp__data,
  output logic                  stUp__pe__ready,
  output logic                  pe__sys__stUp__valid,
  output logic [1:0]            pe__sys__stUp__cntl,
  output logic [DATA_WIDTH-1:0] pe__sys__stUp__data,
  input  logic                  sys__pe__stUp__ready,
  output logic                  stUp__pe__framing_error,
  output logic [15:0]           stUp__pe__pkts_sent
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PKT_BEATS);

  // ---------------------------------------------------------------------------
  // Buffers: payload data, and one length entry per closed packet.
  // ---------------------------------------------------------------------------
  logic                  data_push, data_pop, data_full, data_empty;
  logic [DATA_WIDTH-1:0] data_head;
  logic [CW-1:0]         data_count;
  logic                  lenq_push, lenq_pop, lenq_full, lenq_empty;
  logic [7:0]            lenq_head;
  logic [CW-1:0]         lenq_count;
  logic                  unused_counts;

  assign unused_counts = ^{data_count, lenq_count};

  // ---------------------------------------------------------------------------
  // Input framer
  // ---------------------------------------------------------------------------
  logic       in_pkt_q, in_pkt_d;
  logic [7:0] len_q, len_d;
  logic       drop_q, drop_d;
  logic       ferr_q, ferr_d;
  logic       accept, is_start, illegal;
  logic       close_pkt;
  logic [7:0] next_len;

  assign stUp__pe__ready = !data_full && !lenq_full;
  assign accept          = pe__stUp__valid && stUp__pe__ready;
  assign is_start        = (pe__stUp__cntl == CNTL_SOM) || (pe__stUp__cntl == CNTL_SOP);
  // Start codes are only legal outside a packet, continuation codes only inside.
  assign illegal         = in_pkt_q ? is_start : !is_start;
  assign next_len        = in_pkt_q ? (len_q + 8'd1) : 8'd1;

  always_comb begin
    in_pkt_d  = in_pkt_q;
    len_d     = len_q;
    drop_d    = drop_q;
    ferr_d    = ferr_q;
    data_push = 1'b0;
    close_pkt = 1'b0;
    if (accept) begin
      if (drop_q) begin
        // Discarding the tail of a truncated packet, through its EOP.
        if (pe__stUp__cntl == CNTL_EOP) drop_d = 1'b0;
      end else if (illegal) begin
        ferr_d = 1'b1;
      end else begin
        data_push = 1'b1;
        if ((pe__stUp__cntl == CNTL_SOM) || (pe__stUp__cntl == CNTL_EOP)) begin
          close_pkt = 1'b1;
          in_pkt_d  = 1'b0;
        end else if (next_len == MAX_LEN) begin
          // Oversized packet: this beat becomes the last one sent.
          close_pkt = 1'b1;
          in_pkt_d  = 1'b0;
          ferr_d    = 1'b1;
          drop_d    = 1'b1;
        end else begin
          in_pkt_d = 1'b1;
          len_d    = next_len;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      in_pkt_q <= 1'b0;
      len_q    <= '0;
      drop_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
      len_q    <= len_d;
      drop_q   <= drop_d;
      ferr_q   <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  tx_state_e   state_q, state_d;
  logic [7:0]  tx_len_q, tx_len_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] pkts_q, pkts_d;
  logic        bus_hs, last_hs, load_next, bypass;

  assign bus_hs    = pe__sys__stUp__valid && sys__pe__stUp__ready;
  assign last_hs   = (state_q == ST_PAY) && bus_hs && (rem_q == 8'd1);
  // Points where the FSM may pick up the next packet: idle, or right after an EOP handshake.
  assign load_next = (state_q == ST_IDLE) || last_hs;
  assign lenq_pop  = load_next && !lenq_empty;
  // A packet closing while nothing else is queued skips the length queue, saving a cycle.
  assign bypass    = load_next && lenq_empty && close_pkt;
  assign lenq_push = close_pkt && !bypass;
  assign data_pop  = (state_q == ST_PAY) && bus_hs && !data_empty;

  // State register
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q  <= ST_IDLE;
      tx_len_q <= '0;
      rem_q    <= '0;
      pkts_q   <= '0;
    end else begin
      state_q  <= state_d;
      tx_len_q <= tx_len_d;
      rem_q    <= rem_d;
      pkts_q   <= pkts_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    tx_len_d = tx_len_q;
    rem_d    = rem_q;
    pkts_d   = pkts_q;
    case (state_q)
      ST_IDLE: ;
      ST_HDR: begin
        if (sys__pe__stUp__ready) begin
          state_d = ST_PAY;
          rem_d   = tx_len_q;
        end
      end
      ST_PAY: begin
        if (sys__pe__stUp__ready) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            pkts_d  = pkts_q + 16'd1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (lenq_pop) begin
      state_d  = ST_HDR;
      tx_len_d = lenq_head;
    end else if (bypass) begin
      state_d  = ST_HDR;
      tx_len_d = next_len;
    end
  end

  // Output logic: pure function of registered state, so the bus holds steady under backpressure.
  always_comb begin
    pe__sys__stUp__valid = 1'b0;
    pe__sys__stUp__cntl  = CNTL_SOM;
    pe__sys__stUp__data  = '0;
    case (state_q)
      ST_HDR: begin
        pe__sys__stUp__valid = 1'b1;
        pe__sys__stUp__cntl  = CNTL_SOP;
        pe__sys__stUp__data  = DATA_WIDTH'(make_hdr(8'(PE_ID), tx_len_q));
      end
      ST_PAY: begin
        pe__sys__stUp__valid = 1'b1;
        pe__sys__stUp__cntl  = (rem_q == 8'd1) ? CNTL_EOP : CNTL_MOP;
        pe__sys__stUp__data  = data_head;
      end
      default: ;
    endcase
  end

  assign stUp__pe__framing_error = ferr_q;
  assign stUp__pe__pkts_sent     = pkts_q;

  pe_stack_bus_upstream_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .clk_i      (clk),
    .reset_i    (reset_poweron),
    .push_i     (data_push),
    .push_dat_i (pe__stUp__data),
    .pop_i      (data_pop),
    .pop_dat_o  (data_head),
    .full_o     (data_full),
    .empty_o    (data_empty),
    .count_o    (data_count)
  );

  pe_stack_bus_upstream_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_len_fifo (
    .clk_i      (clk),
    .reset_i    (reset_poweron),
    .push_i     (lenq_push),
    .push_dat_i (next_len),
    .pop_i      (lenq_pop),
    .pop_dat_o  (lenq_head),
    .full_o     (lenq_full),
    .empty_o    (lenq_empty),
    .count_o    (lenq_count)
  );

endmodule

// File: tb/tb_pe_stack_bus_upstream_tx.sv
// Directed, table-driven bench for the upstream stack-bus transmitter (PE_ID = 5).
module tb_pe_stack_bus_upstream_tx;

  localparam logic [1:0] SOM = 2'd0, SOP = 2'd1, MOP = 2'd2, EOP = 2'd3;

  logic        clk = 1'b0;
  logic        reset_poweron;
  logic        in_vld;
  logic [1:0]  in_cntl;
  logic [31:0] in_dat;
  logic        in_rdy;
  logic        bus_vld;
  logic [1:0]  bus_cntl;
  logic [31:0] bus_dat;
  logic        bus_rdy;
  logic        ferr;
  logic [15:0] pkts;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_stack_bus_upstream_tx #(
    .PE_ID         (5),
    .DATA_WIDTH    (32),
    .FIFO_DEPTH    (16),
    .MAX_PKT_BEATS (16)
  ) dut (
    .clk                     (clk),
    .reset_poweron           (reset_poweron),
    .pe__stUp__valid         (in_vld),
    .pe__stUp__cntl          (in_cntl),
    .pe__stUp__data          (in_dat),
    .stUp__pe__ready         (in_rdy),
    .pe__sys__stUp__valid    (bus_vld),
    .pe__sys__stUp__cntl     (bus_cntl),
    .pe__sys__stUp__data     (bus_dat),
    .sys__pe__stUp__ready    (bus_rdy),
    .stUp__pe__framing_error (ferr),
    .stUp__pe__pkts_sent     (pkts)
  );

  typedef struct {
    logic        vld;
    logic [1:0]  cntl;
    logic [31:0] dat;
    logic        sysr;
    logic        e_vld;
    logic [1:0]  e_cntl;
    logic [31:0] e_dat;
    logic        e_rdy;
    logic        e_ferr;
    logic [15:0] e_pkts;
  } vec_t;

  vec_t        vecs[$];
  logic [1:0]  got_cntl[$];
  logic [31:0] got_dat[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic v(input logic vld, input logic [1:0] c, input logic [31:0] d, input logic sr,
                   input logic ev, input logic [1:0] ec, input logic [31:0] ed,
                   input logic erdy, input logic ef, input logic [15:0] ep);
    vec_t t;
    t.vld = vld; t.cntl = c; t.dat = d; t.sysr = sr;
    t.e_vld = ev; t.e_cntl = ec; t.e_dat = ed; t.e_rdy = erdy; t.e_ferr = ef; t.e_pkts = ep;
    vecs.push_back(t);
  endtask

  // Drive one cycle's inputs at the falling edge, then settle so outputs can be sampled.
  task automatic drive(input logic rst, input logic vld, input logic [1:0] c,
                       input logic [31:0] d, input logic sr);
    @(negedge clk);
    reset_poweron = rst;
    in_vld = vld; in_cntl = c; in_dat = d; bus_rdy = sr;
    #1;
  endtask

  // Accept bus beats with ready held high until an EOP is seen or the budget expires.
  task automatic collect_pkt(input int max_cycles, output logic got_eop);
    got_eop = 1'b0;
    got_cntl.delete();
    got_dat.delete();
    for (int c = 0; c < max_cycles && !got_eop; c++) begin
      drive(1'b0, 1'b0, SOM, 32'h0, 1'b1);
      if (bus_vld) begin
        got_cntl.push_back(bus_cntl);
        got_dat.push_back(bus_dat);
        if (bus_cntl == EOP) got_eop = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hs;
    int   idx;
    int   unstable;
    logic seen;
    logic got_eop;
    logic [1:0]  hold_c;
    logic [31:0] hold_d;

    reset_poweron = 1'b1;
    in_vld = 1'b0; in_cntl = SOM; in_dat = '0; bus_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_poweron = 1'b0;
    #1;
    chk("rst_valid", bus_vld, 0);
    chk("rst_cntl",  bus_cntl, 0);
    chk("rst_data",  bus_dat, 0);
    chk("rst_ready", in_rdy, 1);
    chk("rst_ferr",  ferr, 0);
    chk("rst_pkts",  pkts, 0);

    // ---- vector table: 3-beat packet, SOM packet, toggling ready, framing errors ----
    v(1, SOP, 32'hAAAA_0000, 1,  0, SOM, 0, 1, 0, 0);
    v(1, MOP, 32'hAAAA_0001, 1,  0, SOM, 0, 1, 0, 0);
    v(1, EOP, 32'hAAAA_0002, 1,  0, SOM, 0, 1, 0, 0);
    v(0, SOM, 32'h0,         1,  1, SOP, 32'h0503_0000, 1, 0, 0);
    v(0, SOM, 32'h0,         1,  1, MOP, 32'hAAAA_0000, 1, 0, 0);
    v(0, SOM, 32'h0,         1,  1, MOP, 32'hAAAA_0001, 1, 0, 0);
    v(0, SOM, 32'h0,         1,  1, EOP, 32'hAAAA_0002, 1, 0, 0);
    v(1, SOM, 32'h0000_DEAD, 1,  0, SOM, 0, 1, 0, 1);
    v(0, SOM, 32'h0,         1,  1, SOP, 32'h0501_0000, 1, 0, 1);
    v(0, SOM, 32'h0,         1,  1, EOP, 32'h0000_DEAD, 1, 0, 1);
    // back-to-back 2-beat packets, bus ready toggling (vectors 10..23)
    v(1, SOP, 32'hB000_0000, 1,  0, SOM, 0, 1, 0, 2);
    v(1, EOP, 32'hB000_0001, 0,  0, SOM, 0, 1, 0, 2);
    v(1, SOP, 32'hC000_0000, 1,  1, SOP, 32'h0502_0000, 1, 0, 2);
    v(1, EOP, 32'hC000_0001, 0,  1, MOP, 32'hB000_0000, 1, 0, 2);
    v(0, SOM, 32'h0,         1,  1, MOP, 32'hB000_0000, 1, 0, 2);
    v(0, SOM, 32'h0,         0,  1, EOP, 32'hB000_0001, 1, 0, 2);
    v(0, SOM, 32'h0,         1,  1, EOP, 32'hB000_0001, 1, 0, 2);
    v(0, SOM, 32'h0,         0,  1, SOP, 32'h0502_0000, 1, 0, 3);
    v(0, SOM, 32'h0,         1,  1, SOP, 32'h0502_0000, 1, 0, 3);
    v(0, SOM, 32'h0,         0,  1, MOP, 32'hC000_0000, 1, 0, 3);
    v(0, SOM, 32'h0,         1,  1, MOP, 32'hC000_0000, 1, 0, 3);
    v(0, SOM, 32'h0,         0,  1, EOP, 32'hC000_0001, 1, 0, 3);
    v(0, SOM, 32'h0,         1,  1, EOP, 32'hC000_0001, 1, 0, 3);
    v(0, SOM, 32'h0,         0,  0, SOM, 0, 1, 0, 4);
    // MOP outside a packet, SOP inside a packet
    v(1, MOP, 32'h0000_BAD0, 1,  0, SOM, 0, 1, 0, 4);
    v(1, SOP, 32'hD000_0000, 1,  0, SOM, 0, 1, 1, 4);
    v(1, SOP, 32'h0000_BAD1, 1,  0, SOM, 0, 1, 1, 4);
    v(1, EOP, 32'hD000_0001, 1,  0, SOM, 0, 1, 1, 4);
    v(0, SOM, 32'h0,         1,  1, SOP, 32'h0502_0000, 1, 1, 4);
    v(0, SOM, 32'h0,         1,  1, MOP, 32'hD000_0000, 1, 1, 4);
    v(0, SOM, 32'h0,         1,  1, EOP, 32'hD000_0001, 1, 1, 4);
    v(0, SOM, 32'h0,         1,  0, SOM, 0, 1, 1, 5);

    hs = 0;
    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].vld, vecs[i].cntl, vecs[i].dat, vecs[i].sysr);
      chk($sformatf("v%0d_valid", i), bus_vld, vecs[i].e_vld);
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d_cntl", i), bus_cntl, vecs[i].e_cntl);
        chk($sformatf("v%0d_data", i), bus_dat, vecs[i].e_dat);
      end
      chk($sformatf("v%0d_ready", i), in_rdy, vecs[i].e_rdy);
      chk($sformatf("v%0d_ferr", i), ferr, vecs[i].e_ferr);
      chk($sformatf("v%0d_pkts", i), pkts, vecs[i].e_pkts);
      if (i >= 10 && i <= 23 && bus_vld && bus_rdy) hs++;
    end
    chk("toggle_handshakes", hs, 6);

    // ---- reset pulse after header and one payload beat ----
    drive(0, 1, SOP, 32'hF000_0000, 1);
    drive(0, 1, MOP, 32'hF000_0001, 1);
    drive(0, 1, EOP, 32'hF000_0002, 1);
    drive(0, 0, SOM, 32'h0, 1);
    chk("rstmid_hdr", bus_dat, 32'h0503_0000);
    drive(0, 0, SOM, 32'h0, 1);
    chk("rstmid_pay0", bus_dat, 32'hF000_0000);
    drive(1, 0, SOM, 32'h0, 1);
    chk("rstmid_pay1", bus_dat, 32'hF000_0001);
    drive(0, 0, SOM, 32'h0, 1);
    chk("rstmid_valid", bus_vld, 0);
    chk("rstmid_cntl",  bus_cntl, 0);
    chk("rstmid_data",  bus_dat, 0);
    chk("rstmid_ready", in_rdy, 1);
    chk("rstmid_ferr",  ferr, 0);
    chk("rstmid_pkts",  pkts, 0);
    drive(0, 1, SOM, 32'h0000_1234, 1);
    collect_pkt(10, got_eop);
    chk("post_rst_eop_seen", got_eop, 1);
    chk("post_rst_beats", got_dat.size(), 2);
    if (got_dat.size() == 2) begin
      chk("post_rst_hdr_cntl", got_cntl[0], SOP);
      chk("post_rst_hdr_data", got_dat[0], 32'h0501_0000);
      chk("post_rst_pay_cntl", got_cntl[1], EOP);
      chk("post_rst_pay_data", got_dat[1], 32'h0000_1234);
    end
    drive(0, 0, SOM, 32'h0, 1);
    chk("post_rst_pkts", pkts, 1);
    chk("post_rst_ferr", ferr, 0);

    // ---- 20-beat packet against 16-beat limit, bus stalled ----
    idx = 0; seen = 1'b0; unstable = 0; hold_c = '0; hold_d = '0;
    for (int c = 0; c < 30; c++) begin
      drive(0, idx < 20, (idx == 0) ? SOP : ((idx == 19) ? EOP : MOP), 32'hE000_0000 + 32'(idx), 0);
      if (bus_vld) begin
        if (!seen) begin
          seen = 1'b1; hold_c = bus_cntl; hold_d = bus_dat;
        end else if (bus_cntl !== hold_c || bus_dat !== hold_d) begin
          unstable++;
        end
      end
      if (in_vld && in_rdy) idx++;
    end
    chk("trunc_accepted_while_stalled", idx, 16);
    chk("trunc_ready_low", in_rdy, 0);
    chk("trunc_hdr_valid", bus_vld, 1);
    chk("trunc_hdr_cntl", bus_cntl, SOP);
    chk("trunc_hdr_data", bus_dat, 32'h0510_0000);
    chk("trunc_hold_stable", unstable, 0);
    chk("trunc_ferr", ferr, 1);

    got_cntl.delete();
    got_dat.delete();
    got_eop = 1'b0;
    for (int c = 0; c < 80 && !(got_eop && idx == 20); c++) begin
      drive(0, idx < 20, (idx == 19) ? EOP : MOP, 32'hE000_0000 + 32'(idx), 1);
      if (bus_vld) begin
        got_cntl.push_back(bus_cntl);
        got_dat.push_back(bus_dat);
        if (bus_cntl == EOP) got_eop = 1'b1;
      end
      if (in_vld && in_rdy) idx++;
    end
    chk("trunc_eop_seen", got_eop, 1);
    chk("trunc_tail_consumed", idx, 20);
    chk("trunc_bus_beats", got_dat.size(), 17);
    if (got_dat.size() == 17) begin
      for (int k = 1; k <= 16; k++) begin
        chk($sformatf("trunc_pay%0d_data", k), got_dat[k], 32'hE000_0000 + 32'(k - 1));
        chk($sformatf("trunc_pay%0d_cntl", k), got_cntl[k], (k == 16) ? EOP : MOP);
      end
    end
    drive(0, 0, SOM, 32'h0, 1);
    drive(0, 0, SOM, 32'h0, 1);
    chk("trunc_bus_idle_after", bus_vld, 0);
    chk("trunc_pkts", pkts, 2);
    chk("trunc_ferr_sticky", ferr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_stack_bus_upstream_tx.md
Name: pe_stack_bus_upstream_tx

Overview:
- PE-side transmitter for the stack bus upstream direction (PE array -> manager array).
- Accepts framed result beats from the PE streaming-ops core and buffers whole packets in a FIFO.
- Prepends a header beat carrying PE_ID and beat count, then drives the packet onto the upstream stack bus under valid/ready flow control.
- Instantiated once per PE; its bus outputs connect through the stack bus to the manager's upstream receiver.

Parameters:
- PE_ID, 0, 8-bit identifier placed in the header beat.
- DATA_WIDTH, 32, payload beat width; must be >= 32.
- FIFO_DEPTH, 16, payload beat storage; power of 2.
- MAX_PKT_BEATS, 16, maximum payload beats per packet; must be <= FIFO_DEPTH and <= 255.

Ports:
- clk  input  1  system clock.
- reset_poweron  input  1  synchronous, active-high reset.
- pe__stUp__valid  input  1  core beat valid.
- pe__stUp__cntl  input  2  framing: 0=SOM (single-beat packet), 1=SOP, 2=MOP, 3=EOP.
- pe__stUp__data  input  DATA_WIDTH  core beat data.
- stUp__pe__ready  output  1  transmitter can accept a beat.
- pe__sys__stUp__valid  output  1  bus beat valid.
- pe__sys__stUp__cntl  output  2  bus framing, same encoding as pe__stUp__cntl.
- pe__sys__stUp__data  output  DATA_WIDTH  bus beat data.
- sys__pe__stUp__ready  input  1  manager-side ready.
- stUp__pe__framing_error  output  1  sticky framing-error flag.
- stUp__pe__pkts_sent  output  16  count of completed bus packets; wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset_poweron.
- Reset values:
  - All outputs 0, except stUp__pe__ready = 1.
  - FIFO emptied, packet-length queue emptied, FSM = IDLE.
  - Reset asserted mid-packet aborts the packet. The partial packet is discarded, no EOP is emitted, and the bus is idle the cycle after the reset edge.
- Input handshake:
  - A beat is accepted when pe__stUp__valid && stUp__pe__ready.
  - stUp__pe__ready = !fifo_full && !lenq_full.
- Input framer:
  - Tracks in_pkt and a beat counter len (1..MAX_PKT_BEATS).
  - SOM or SOP outside a packet starts a packet. SOM immediately closes it with len=1.
  - EOP or MOP outside a packet: beat dropped, framing_error set.
  - SOP or SOM inside a packet: beat dropped, framing_error set, current packet continues.
  - When a beat would be number MAX_PKT_BEATS and is not EOP: write it as the last beat, push the length, set framing_error, and set a drop flag. Beats are then dropped up to and including the next EOP.
  - On packet close, push len into the length queue (depth FIFO_DEPTH).
- FIFO: stores data only. Framing on the bus is regenerated from the queued length.
- FSM:
  - IDLE: when the length queue is non-empty, pop len into tx_len and go to HDR.
  - HDR: drive valid=1, cntl=SOP, data = {PE_ID[7:0], tx_len[7:0], 16'h0}, zero-extended to DATA_WIDTH. On ready, go to PAY with rem = tx_len.
  - PAY: drive the FIFO head. cntl = EOP when rem==1, else MOP. On ready, pop and decrement rem.
  - After the EOP handshake: increment pkts_sent and go to IDLE. If another length is already queued, pop it and go straight to HDR with no bubble.
- Bus rule: once valid is high, valid/cntl/data hold stable until sys__pe__stUp__ready is sampled high.
- Latency: core EOP/SOM accepted at edge N -> header valid from cycle N+1, provided the FSM is IDLE.
- Throughput: 1 beat/cycle with ready continuously high. A packet of L payload beats occupies L+1 bus cycles.
- Simultaneous events: an accept and a pop in the same cycle keep occupancy unchanged. A full FIFO with a pop in the same cycle still deasserts input ready; no combinational ready-through.

Decomposition:
- Shared package / stack_interface.vh holds:
  - cntl encodings (SOM/SOP/MOP/EOP);
  - header field offsets (PE_ID [31:24], LEN [23:16]);
  - STUP_DATA_WIDTH.
- One natural sub-module: pe_stack_bus_upstream_fifo, a generic synchronous FIFO with full/empty/count. It is instantiated twice: once for data and once for lengths.

Test Plan:
- PE_ID=5; core sends SOP A0, MOP A1, EOP A2; ready=1 -> bus shows 0x05030000 (SOP), A0 (MOP), A1 (MOP), A2 (EOP) on consecutive cycles; pkts_sent=1.
- Single SOM 0xDEAD -> header 0x05010000 (SOP), then 0xDEAD (EOP); framing_error stays 0.
- Two back-to-back 2-beat packets, ready toggling 1,0,1,0 -> no beat lost or duplicated; data stable during ready=0; 6 handshakes total; pkts_sent=2.
- MOP before any SOP, and SOP inside a packet -> those beats dropped; framing_error=1 and sticky until reset; the legal packet is transmitted intact.
- 20-beat packet with MAX_PKT_BEATS=16 and bus ready held 0 -> stUp__pe__ready=0 once the FIFO is full; on ready release, the header shows LEN=16, 16 payload beats are sent, and the trailing 4 input beats are dropped.
- reset_poweron pulsed for one cycle after HDR and 1 payload beat -> all outputs 0 the next cycle; a new packet then transmits correctly and pkts_sent restarts from 0.
